// File: rtl/spi_regfile_ctrl_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | spi_regfile_pkg : shared types and frame-geometry helpers for the SPI    |
// | register-file peripheral.                       Revision: 1.0            |
// +-------------------------------------------------------------------------+
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam int   ADDR_OFS = 1;

  // Frame layout, MSB first: R/W bit, address field, data field.
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int data_ofs(input int addr_w);
    return ADDR_OFS + addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_regfile_ctrl_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | spi_regfile_ctrl_if : SPI pin bundle between controller and peripheral. |
// |                                                 Revision: 1.0            |
// +-------------------------------------------------------------------------+
interface spi_regfile_ctrl_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
  modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface
`default_nettype wire

// File: rtl/spi_regfile_ctrl_in_sync.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | spi_in_sync : synchronises sclk/ncs/copi into clk and flags sclk/ncs     |
// | edges as one-clk pulses.                        Revision: 1.0            |
// +-------------------------------------------------------------------------+
module spi_in_sync #(
  parameter int SYNC_LEN = 2
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  sclk,
  input  wire  ncs,
  input  wire  copi,
  output logic ncs_s,
  output logic copi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ncs_rise
);

  logic [SYNC_LEN-1:0] r_sclk_sync;
  logic [SYNC_LEN-1:0] r_ncs_sync;
  logic [SYNC_LEN-1:0] r_copi_sync;
  logic                r_sclk_prev;
  logic                r_ncs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_ncs_sync  <= '0;
      r_copi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ncs_prev  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_LEN-2:0], sclk};
      r_ncs_sync  <= {r_ncs_sync[SYNC_LEN-2:0], ncs};
      r_copi_sync <= {r_copi_sync[SYNC_LEN-2:0], copi};
      r_sclk_prev <= r_sclk_sync[SYNC_LEN-1];
      r_ncs_prev  <= r_ncs_sync[SYNC_LEN-1];
    end
  end

  // copi goes through the same depth as sclk so data and edge stay aligned.
  assign ncs_s     = r_ncs_sync[SYNC_LEN-1];
  assign copi_s    = r_copi_sync[SYNC_LEN-1];
  assign sclk_rise = r_sclk_sync[SYNC_LEN-1] & ~r_sclk_prev;
  assign sclk_fall = ~r_sclk_sync[SYNC_LEN-1] & r_sclk_prev;
  assign ncs_rise  = r_ncs_sync[SYNC_LEN-1] & ~r_ncs_prev;

endmodule
`default_nettype wire

// File: rtl/spi_regfile_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | spi_regfile_ctrl : SPI-addressed register file with read-back, write    |
// | strobes and aborted-frame detection.            Revision: 1.0            |
// +-------------------------------------------------------------------------+
module spi_regfile_ctrl
  import spi_regfile_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5,
  parameter int SYNC_LEN = 2,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0
) (
  input  wire                           clk,
  input  wire                           rst_n,
  spi_regfile_ctrl_if.slave             spi,
  output logic [NUM_REGS*DATA_W-1:0]    regs,
  output logic [NUM_REGS-1:0]           wr_strobe,
  output logic                          frame_err
);

  localparam int          c_frame_len = frame_len(ADDR_W, DATA_W);
  localparam int          c_data_ofs  = data_ofs(ADDR_W);
  localparam int          c_cnt_w     = $clog2(c_frame_len + 1);
  localparam int unsigned c_num_regs  = NUM_REGS;
  localparam logic [c_cnt_w-1:0] c_last_addr = c_cnt_w'(c_data_ofs - 1);
  localparam logic [c_cnt_w-1:0] c_last_data = c_cnt_w'(c_frame_len - 1);

  logic w_ncs_s;
  logic w_copi_s;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_ncs_rise;
  logic w_sample;
  logic w_launch;
  logic w_active;

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_strobe;
  logic                r_frame_err;
  logic                r_wr_pend;
  logic                r_armed;
  logic                r_cipo;
  logic                r_cipo_oe;

  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [DATA_W-1:0]   w_rd_val;

  spi_in_sync #(
    .SYNC_LEN (SYNC_LEN)
  ) u_in_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (spi.sclk),
    .ncs       (spi.ncs),
    .copi      (spi.copi),
    .ncs_s     (w_ncs_s),
    .copi_s    (w_copi_s),
    .sclk_rise (w_sclk_rise),
    .sclk_fall (w_sclk_fall),
    .ncs_rise  (w_ncs_rise)
  );

  if (CPOL == CPHA) begin : g_sample_rise
    assign w_sample = w_sclk_rise;
    assign w_launch = w_sclk_fall;
  end else begin : g_sample_fall
    assign w_sample = w_sclk_fall;
    assign w_launch = w_sclk_rise;
  end

  // Sync chains reset low, so ncs must be seen high once before a frame can
  // start; this also forces a fresh ncs fall after a mid-frame reset.
  assign w_active = r_armed & ~w_ncs_s;

  assign w_addr_nxt = ADDR_W'({r_addr, w_copi_s});
  assign w_data_nxt = DATA_W'({r_data, w_copi_s});

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < c_num_regs);
  endfunction

  always_comb begin
    w_rd_val = '0;
    for (int unsigned k = 0; k < c_num_regs; k++) begin
      if (32'(w_addr_nxt) == k) w_rd_val = r_regs[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_tx        <= '0;
      r_wr_strobe <= '0;
      r_frame_err <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_armed     <= 1'b0;
      r_cipo      <= 1'b0;
      r_cipo_oe   <= 1'b0;
      for (int unsigned k = 0; k < c_num_regs; k++) r_regs[k] <= '0;
    end else begin
      r_wr_strobe <= '0;
      r_frame_err <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_armed     <= r_armed | w_ncs_s;
      r_cipo_oe   <= w_active;

      // Commit one clk after the final data sample; r_addr/r_data are frozen in DONE.
      for (int unsigned k = 0; k < c_num_regs; k++) begin
        if (r_wr_pend && (32'(r_addr) == k)) begin
          r_regs[k]      <= r_data;
          r_wr_strobe[k] <= 1'b1;
        end
      end

      if (!w_active) begin
        if (w_ncs_rise && (r_state inside {CMD, ADDR, DATA})) r_frame_err <= 1'b1;
        r_state <= IDLE;
        r_cnt   <= '0;
        r_cipo  <= 1'b0;
      end else begin
        if (w_sample) begin
          case (r_state)
            IDLE: begin
              r_rw    <= w_copi_s;
              r_cnt   <= c_cnt_w'(1);
              r_state <= CMD;
            end
            CMD, ADDR: begin
              r_addr <= w_addr_nxt;
              r_cnt  <= r_cnt + c_cnt_w'(1);
              if (r_cnt == c_last_addr) begin
                r_state <= DATA;
                // Snapshot uses the register value before any same-cycle commit.
                r_tx    <= (r_rw != RW_WRITE && f_in_range(w_addr_nxt)) ? w_rd_val : '0;
              end else begin
                r_state <= ADDR;
              end
            end
            DATA: begin
              r_data <= w_data_nxt;
              r_cnt  <= r_cnt + c_cnt_w'(1);
              if (r_cnt == c_last_data) begin
                r_state   <= DONE;
                r_wr_pend <= (r_rw == RW_WRITE) && f_in_range(r_addr);
              end
            end
            DONE: ;
            default: r_state <= IDLE;
          endcase
        end
        if (w_launch && (r_state == DATA)) begin
          r_cipo <= r_tx[DATA_W-1];
          r_tx   <= r_tx << 1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs[k*DATA_W +: DATA_W] = r_regs[k];
  end

  assign wr_strobe   = r_wr_strobe;
  assign frame_err   = r_frame_err;
  assign spi.cipo    = r_cipo;
  assign spi.cipo_oe = r_cipo_oe;

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_spi_regfile_ctrl : drives a mode-0 and a mode-3 instance with SPI     |
// | frames and compares against a register-array model.  Revision: 1.0       |
// +-------------------------------------------------------------------------+
module tb_spi_regfile_ctrl;

  localparam int SYNC_LEN  = 2;
  localparam int NUM_REGS  = 5;
  localparam int FRAME_LEN = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_regfile_ctrl_if spi0 ();
  spi_regfile_ctrl_if spi3 ();

  logic [39:0] regs0, regs3;
  logic [4:0]  stb0, stb3;
  logic        err0, err3;

  spi_regfile_ctrl #(.CPOL(0), .CPHA(0), .SYNC_LEN(SYNC_LEN)) dut0 (
    .clk(clk), .rst_n(rst_n), .spi(spi0), .regs(regs0), .wr_strobe(stb0), .frame_err(err0));
  spi_regfile_ctrl #(.CPOL(1), .CPHA(1), .SYNC_LEN(SYNC_LEN)) dut3 (
    .clk(clk), .rst_n(rst_n), .spi(spi3), .regs(regs3), .wr_strobe(stb3), .frame_err(err3));

  int         stb_hits [2];
  int         err_hits [2];
  int         stb_cyc  [2];
  logic [4:0] stb_or   [2];

  always @(negedge clk) begin
    if (|stb0) begin stb_hits[0]++; stb_or[0] |= stb0; stb_cyc[0] = cyc; end
    if (|stb3) begin stb_hits[1]++; stb_or[1] |= stb3; stb_cyc[1] = cyc; end
    if (err0) err_hits[0]++;
    if (err3) err_hits[1]++;
  end

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] mem [2][NUM_REGS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_sclk(input int m, input logic v);
    if (m == 0) spi0.sclk = v; else spi3.sclk = v;
  endtask
  task automatic set_ncs(input int m, input logic v);
    if (m == 0) spi0.ncs = v; else spi3.ncs = v;
  endtask
  task automatic set_copi(input int m, input logic v);
    if (m == 0) spi0.copi = v; else spi3.copi = v;
  endtask
  function automatic logic get_cipo(input int m);
    return (m == 0) ? spi0.cipo : spi3.cipo;
  endfunction
  function automatic logic get_oe(input int m);
    return (m == 0) ? spi0.cipo_oe : spi3.cipo_oe;
  endfunction
  function automatic logic [39:0] model_vec(input int m);
    logic [39:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[k*8 +: 8] = mem[m][k];
    return v;
  endfunction

  task automatic half();
    repeat (5) @(posedge clk);
    #2;
  endtask

  // One SPI transaction as the controller sees it; m=0 is mode 0, m=1 is mode 3.
  task automatic spi_frame(input int m, input int nbits, input logic [23:0] bits, input bit keep_cs,
                           output logic [7:0] rx, output int last_cyc, output logic oe_ok);
    logic cpol;
    logic cpha;
    cpol = (m != 0);
    cpha = (m != 0);
    rx = '0; oe_ok = 1'b1; last_cyc = 0;
    set_ncs(m, 1'b1);
    repeat (6) @(posedge clk);
    #2;
    set_ncs(m, 1'b0);
    half();
    for (int i = 0; i < nbits; i++) begin
      logic b;
      b = bits[23-i];
      if (!cpha) begin
        set_copi(m, b);
      end else begin
        set_sclk(m, ~cpol);
        set_copi(m, b);
      end
      half();
      if (i >= 8 && i < 16) rx = {rx[6:0], get_cipo(m)};
      oe_ok &= get_oe(m);
      set_sclk(m, cpha ? cpol : ~cpol);
      if (i == FRAME_LEN - 1) last_cyc = cyc;
      half();
      if (!cpha) set_sclk(m, cpol);
    end
    if (!keep_cs) begin
      set_ncs(m, 1'b1);
      repeat (8) @(posedge clk);
      #2;
    end
  endtask

  task automatic do_frame(input string tag, input int m, input int nbits,
                          input logic rw, input logic [6:0] addr, input logic [7:0] data);
    logic [7:0] rx, exp_rd;
    logic [4:0] exp_stb;
    logic       oe_ok;
    int         lc;
    bit         complete, inr;
    complete = (nbits >= FRAME_LEN);
    inr      = (addr < NUM_REGS);
    exp_rd   = (!rw && inr) ? mem[m][addr] : 8'h00;
    exp_stb  = (complete && rw && inr) ? 5'(1 << addr) : 5'b0;
    if (exp_stb != 0) mem[m][addr] = data;
    stb_hits[m] = 0; err_hits[m] = 0; stb_or[m] = '0;
    spi_frame(m, nbits, {rw, addr, data, 8'($urandom)}, 1'b0, rx, lc, oe_ok);
    chk({tag, "/regs"}, (m == 0) ? regs0 : regs3, model_vec(m));
    chk({tag, "/stb_n"}, stb_hits[m], (exp_stb != 0) ? 1 : 0);
    chk({tag, "/stb_mask"}, stb_or[m], exp_stb);
    chk({tag, "/frame_err_n"}, err_hits[m], complete ? 0 : 1);
    chk({tag, "/oe_in_frame"}, oe_ok, 1'b1);
    chk({tag, "/oe_idle"}, get_oe(m), 1'b0);
    chk({tag, "/cipo_idle"}, get_cipo(m), 1'b0);
    if (exp_stb != 0) chk({tag, "/latency"}, stb_cyc[m] - lc, SYNC_LEN + 2);
    if (complete && !rw) chk({tag, "/rdata"}, rx, exp_rd);
  endtask

  initial begin
    logic [7:0] rx;
    logic       oe_ok;
    int         lc;
    spi0.sclk = 1'b0; spi0.ncs = 1'b1; spi0.copi = 1'b0;
    spi3.sclk = 1'b1; spi3.ncs = 1'b1; spi3.copi = 1'b0;
    for (int m = 0; m < 2; m++) for (int k = 0; k < NUM_REGS; k++) mem[m][k] = 8'h00;

    repeat (3) @(posedge clk);
    #2;
    chk("reset/regs0", regs0, 40'h0);
    chk("reset/regs3", regs3, 40'h0);
    chk("reset/stb", {stb0, stb3}, 10'h0);
    chk("reset/err", {err0, err3}, 2'b00);
    chk("reset/cipo", {spi0.cipo, spi3.cipo}, 2'b00);
    chk("reset/oe", {spi0.cipo_oe, spi3.cipo_oe}, 2'b00);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;

    do_frame("m0_wr4", 0, 16, 1'b1, 7'h04, 8'hA5);
    do_frame("m3_wr2", 1, 16, 1'b1, 7'h02, 8'h3C);
    do_frame("m3_rd2", 1, 16, 1'b0, 7'h02, 8'h00);
    do_frame("oor_wr", 0, 16, 1'b1, 7'h10, 8'hFF);
    do_frame("oor_rd", 0, 16, 1'b0, 7'h10, 8'h00);
    do_frame("abort12", 0, 12, 1'b1, 7'h01, 8'h55);
    do_frame("full16", 0, 16, 1'b1, 7'h01, 8'h55);
    do_frame("abort3_m3", 1, 3, 1'b1, 7'h01, 8'h77);
    do_frame("overlong", 0, 20, 1'b1, 7'h00, 8'h81);
    do_frame("m0_rd0", 0, 16, 1'b0, 7'h00, 8'h00);

    for (int t = 0; t < 16; t++) begin
      int         m, nb;
      logic       rw;
      logic [6:0] a;
      logic [7:0] d;
      m  = int'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      a  = 7'($urandom_range(0, 9));
      d  = 8'($urandom_range(0, 255));
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : FRAME_LEN;
      do_frame($sformatf("rand%0d", t), m, nb, rw, a, d);
    end

    // Reset in the middle of a frame, with ncs still held low.
    spi_frame(0, 9, {1'b1, 7'h03, 8'hAA, 8'h00}, 1'b1, rx, lc, oe_ok);
    rst_n = 1'b0;
    #1;
    chk("midrst/regs0", regs0, 40'h0);
    chk("midrst/regs3", regs3, 40'h0);
    chk("midrst/cipo", spi0.cipo, 1'b0);
    chk("midrst/oe", spi0.cipo_oe, 1'b0);
    for (int m = 0; m < 2; m++) for (int k = 0; k < NUM_REGS; k++) mem[m][k] = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    do_frame("after_rst", 0, 16, 1'b1, 7'h03, 8'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
